dma_cmd_queue: RTL

- Buffers DMA commands from the core's execute stage in a DEPTH-entry in-order queue, so the pipeline no longer stalls on every DMA instruction.
- Dispatches queued commands to NUM_ENG DMA engines. Commands whose PIM-select masks overlap an in-flight command are held back, which preserves ordering per PIM bank.
- Sits between the core's DMA interface and the DMA engines. The core uses `idle_o` as a fence before touching PIM-mapped data.

---
 rtl/dma_cmd_queue.sv | 90 +++++++++
 1 files changed

// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: in-order DMA command queue dispatching to NUM_ENG engines
// while holding back commands whose PIM bank mask overlaps an in-flight command.
module dma_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int NUM_ENG = 2,
  parameter int SEL_W   = 4,
  parameter int SIZE_W  = 13,
  parameter int ADDR_W  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [2:0]                    cmd_funct3_i,
  input  logic [SEL_W-1:0]              cmd_sel_pim_i,
  input  logic [SIZE_W-1:0]             cmd_size_i,
  input  logic [ADDR_W-1:0]             cmd_addr_i,
  output logic [NUM_ENG-1:0]            eng_start_o,
  output logic [3*NUM_ENG-1:0]          eng_funct3_o,
  output logic [SEL_W*NUM_ENG-1:0]      eng_sel_pim_o,
  output logic [SIZE_W*NUM_ENG-1:0]     eng_size_o,
  output logic [ADDR_W*NUM_ENG-1:0]     eng_addr_o,
  input  logic [NUM_ENG-1:0]            eng_done_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          idle_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [2:0]        funct3;
    logic [SEL_W-1:0]  sel;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
  } cmd_t;
  cmd_t mem_q [DEPTH];
  cmd_t eng_q [NUM_ENG];
  cmd_t eng_d [NUM_ENG];
  cmd_t head, in_cmd;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [NUM_ENG-1:0] inflight_q, inflight_d, start_q, start_d, free_lo;
  logic push, pop, hazard;
  assign in_cmd = '{funct3: cmd_funct3_i, sel: cmd_sel_pim_i, size: cmd_size_i, addr: cmd_addr_i};
  assign head = mem_q[rd_q];
  assign cmd_ready_o = count_q < CW'(DEPTH);
  assign idle_o = (count_q == '0) && (inflight_q == '0);
  assign count_o = count_q;
  assign eng_start_o = start_q;
  // Zero-size commands are accepted but never take a slot.
  assign push = cmd_valid_i && cmd_ready_o && (cmd_size_i != '0);
  // An engine's output sel field doubles as its in-flight bank mask.
  always_comb begin
    hazard = 1'b0;
    free_lo = '0;
    for (int e = NUM_ENG - 1; e >= 0; e--) begin
      hazard = hazard | (inflight_q[e] && |(eng_q[e].sel & head.sel));
      free_lo = inflight_q[e] ? free_lo : (NUM_ENG'(1) << e);
    end
    pop = (count_q != '0) && !hazard && (free_lo != '0);
    start_d = pop ? free_lo : '0;
    for (int e = 0; e < NUM_ENG; e++) eng_d[e] = start_d[e] ? head : eng_q[e];
    inflight_d = (inflight_q & ~eng_done_i) | start_d;
    rd_d = rd_q + PW'(pop);
    wr_d = wr_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk_i) if (push) mem_q[wr_q] <= in_cmd;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      inflight_q <= '0;
      start_q <= '0;
      for (int e = 0; e < NUM_ENG; e++) eng_q[e] <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      start_q <= start_d;
      eng_q <= eng_d;
    end
  for (genvar e = 0; e < NUM_ENG; e++) begin : g_out
    assign eng_funct3_o[3*e +: 3] = eng_q[e].funct3;
    assign eng_sel_pim_o[SEL_W*e +: SEL_W] = eng_q[e].sel;
    assign eng_size_o[SIZE_W*e +: SIZE_W] = eng_q[e].size;
    assign eng_addr_o[ADDR_W*e +: ADDR_W] = eng_q[e].addr;
  end
endmodule
